// File: rtl/dac_controller_pkg.sv
// Shared definitions for the DAC serial transmit controller.
// Holds FSM state encodings, frame geometry, power-down codes and the gap floor helper.
// No logic; imported by dac_controller and dac_frame_shifter.
package dac_controller_pkg;

  // DAC frame is 16 bits: 2 don't-care, 2 power-down, 12 data.
  localparam int FRAME_BITS    = 16;
  localparam int DAC_DATA_BITS = 12;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GAP   = 3'd4
  } dac_state_t;

  // Power-down field (DB13:12) encodings.
  typedef enum logic [1:0] {
    PD_NORMAL   = 2'b00,
    PD_1K_GND   = 2'b01,
    PD_100K_GND = 2'b10,
    PD_HIZ      = 2'b11
  } dac_pd_t;

  // Effective inter-frame gap: the requested count, but never below the floor.
  function automatic logic [7:0] gap_floor(input logic [7:0] req, input logic [7:0] floor_v);
    return (req < floor_v) ? floor_v : req;
  endfunction

endpackage

// File: rtl/dac_controller_frame_shifter.sv
// dac_frame_shifter: 16-bit frame shift register, bit counter and SCLK generator.
// Latency: load seen on sclk/din the next cycle; one bit per two clk cycles while shift_en.
// Backpressure: none; the parent FSM owns sequencing via load/shift_en/clr.
// Ports: load (capture word), shift_en (SHIFT state), clr (zero din for idle), word,
//        sclk (idles high), din (current frame bit), last_bit (final sclk-low cycle of the frame).
module dac_frame_shifter
  import dac_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic                  clr,
  input  logic [FRAME_BITS-1:0] word,
  output logic                  sclk,
  output logic                  din,
  output logic                  last_bit
);

  localparam int CNT_W = $clog2(FRAME_BITS);

  logic [FRAME_BITS-1:0] sreg;
  logic [CNT_W-1:0]      bit_cnt;

  // din is the MSB of the shift register, so it is a registered output.
  assign din = sreg[FRAME_BITS-1];

  // High in the sclk-low half of the last bit: the following edge is the
  // 16th falling edge already taken, so the frame ends there.
  assign last_bit = shift_en && !sclk && (bit_cnt == CNT_W'(FRAME_BITS - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg    <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b1;
    end else if (load) begin
      sreg    <= word;
      bit_cnt <= '0;
      sclk    <= 1'b1;
    end else if (shift_en) begin
      sclk <= ~sclk;
      // Advance on the 0->1 edge; after the last bit, hold bit 0 on din.
      if (!sclk && !last_bit) begin
        sreg    <= {sreg[FRAME_BITS-2:0], 1'b0};
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end else if (clr) begin
      sreg <= '0;
    end
  end

endmodule

// File: rtl/dac_controller.sv
// dac_controller: pops DATA_BITS codes from an upstream FIFO and sends each as one 16-bit DAC frame, MSB first, sclk=clk/2.
// Latency: FIFO non-empty seen in IDLE at N -> pop strobe at N+1 -> sync_n low at N+3; frame = 32 cycles sync_n low.
// Backpressure: pops only when dac_enable && !fifo_empty, one registered pop per frame; dropping enable lets the frame finish.
// Ports: clk, reset (async, active-low), dac_enable, pd_mode, gap_counts, fifo_empty, fifo_read_data ->
//        fifo_read_enable, dac_update_done, busy, frame_count, sclk, sync_n, din (all registered).
module dac_controller
  import dac_controller_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int GAP_MIN   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dac_enable,
  input  logic [1:0]           pd_mode,
  input  logic [7:0]           gap_counts,
  input  logic                 fifo_empty,
  input  logic [DATA_BITS-1:0] fifo_read_data,
  output logic                 fifo_read_enable,
  output logic                 dac_update_done,
  output logic                 busy,
  output logic [15:0]          frame_count,
  output logic                 sclk,
  output logic                 sync_n,
  output logic                 din
);

  localparam logic [7:0] GAP_MIN_L = 8'(GAP_MIN);

  dac_state_t state, state_nxt;

  logic                     fetch_ok;
  logic                     last_bit;
  logic                     gap_end;
  logic [7:0]               gap_len;
  logic [7:0]               gap_cnt;
  logic [DAC_DATA_BITS-1:0] data_field;
  logic [FRAME_BITS-1:0]    frame_word;

  assign fetch_ok = dac_enable && !fifo_empty;

  // gap_cnt already counts the current GAP cycle, so the state lasts gap_len cycles.
  assign gap_end = (gap_cnt >= gap_len);

  // FIFO code left-justified in the 12-bit data field, LSBs zero.
  assign data_field = DAC_DATA_BITS'(fifo_read_data) << (DAC_DATA_BITS - DATA_BITS);
  assign frame_word = {2'b00, pd_mode, data_field};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fetch_ok) state_nxt = ST_FETCH;
      ST_FETCH: state_nxt = ST_LOAD;
      ST_LOAD:  state_nxt = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_nxt = ST_GAP;
      ST_GAP:   if (gap_end) state_nxt = fetch_ok ? ST_FETCH : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      fifo_read_enable <= 1'b0;
      busy             <= 1'b0;
      sync_n           <= 1'b1;
      dac_update_done  <= 1'b0;
      gap_len          <= GAP_MIN_L;
      gap_cnt          <= '0;
    end else begin
      state            <= state_nxt;
      fifo_read_enable <= (state_nxt == ST_FETCH);
      busy             <= (state_nxt != ST_IDLE);
      sync_n           <= (state_nxt != ST_SHIFT);
      dac_update_done  <= last_bit;
      if (last_bit) begin
        // gap_counts is latched on GAP entry; later changes wait for the next frame.
        gap_len <= gap_floor(gap_counts, GAP_MIN_L);
        gap_cnt <= 8'd1;
      end else if ((state == ST_GAP) && !gap_end) begin
        gap_cnt <= gap_cnt + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      frame_count <= '0;
    end else if (last_bit) begin
      frame_count <= frame_count + 16'd1;
    end
  end

  dac_frame_shifter u_shifter (
    .clk      (clk),
    .reset    (reset),
    .load     (state == ST_LOAD),
    .shift_en (state == ST_SHIFT),
    .clr      (state_nxt == ST_IDLE),
    .word     (frame_word),
    .sclk     (sclk),
    .din      (din),
    .last_bit (last_bit)
  );

endmodule

// File: tb/tb_dac_controller.sv
// Testbench for dac_controller: FIFO model, DAC receiver model and per-cycle protocol checks.
// Latency/backpressure: n/a (bench).
// Directed tests: single frame, back-to-back with gap, gap floor + pd latch, enable drop, reset abort, counter wrap.
`timescale 1ns/1ps
module tb_dac_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        dac_enable = 1'b0;
  logic [1:0]  pd_mode = 2'b00;
  logic [7:0]  gap_counts = 8'd3;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_read_data = 8'h00;
  logic        fifo_read_enable;
  logic        dac_update_done;
  logic        busy;
  logic [15:0] frame_count;
  logic        sclk;
  logic        sync_n;
  logic        din;

  dac_controller #(.DATA_BITS(8), .GAP_MIN(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .dac_enable       (dac_enable),
    .pd_mode          (pd_mode),
    .gap_counts       (gap_counts),
    .fifo_empty       (fifo_empty),
    .fifo_read_data   (fifo_read_data),
    .fifo_read_enable (fifo_read_enable),
    .dac_update_done  (dac_update_done),
    .busy             (busy),
    .frame_count      (frame_count),
    .sclk             (sclk),
    .sync_n           (sync_n),
    .din              (din)
  );

  always #10 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Upstream FIFO: data appears the cycle after the pop strobe.
  logic [7:0] fq[$];

  always @(posedge clk) begin
    if (fifo_read_enable && fq.size() > 0) begin
      fifo_read_data <= fq.pop_front();
      fifo_empty     <= (fq.size() == 0);
    end
  end

  // Protocol-level model state.
  int          cyc = 0;
  bit          prev_sync = 1'b1, prev_sclk = 1'b1, prev_din = 1'b0, prev_rd = 1'b0;
  logic [7:0]  prev_gap = 8'd0;
  bit          pred_rd = 1'b0, exp_busy = 1'b0, in_gap = 1'b0, b2b = 1'b0;
  int          rd_cyc = 0, rise_cyc = 0, gap_eff = 2, lowlen = 0, nbits = 0;
  logic [15:0] cap = 16'h0;
  logic [15:0] model_fc = 16'h0;
  logic [15:0] expq[$];
  logic [15:0] got_words[$];
  int          hi_q[$];
  int          rdgap_q[$];
  int          pops = 0, dones = 0;

  always @(negedge clk) begin
    bit rise, fall, nxt_rd, nxt_busy;
    cyc++;
    if (!reset) begin
      chk("reset_values", {sync_n, sclk, din, fifo_read_enable, dac_update_done, busy, frame_count},
          {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
      model_fc = 16'h0;
      pred_rd  = 1'b0;
      exp_busy = 1'b0;
      in_gap   = 1'b0;
      b2b      = 1'b0;
      expq.delete();
    end else begin
      rise = !prev_sync && sync_n;
      fall = prev_sync && !sync_n;
      if (rise) begin
        chk("sync_low_cycles", lowlen, 32);
        chk("bits_sampled", nbits, 16);
        if (expq.size() == 0) chk("frame_has_pop", expq.size(), 1);
        else chk("frame_word", cap, expq.pop_front());
        got_words.push_back(cap);
        model_fc++;
        dones++;
        gap_eff  = (prev_gap < 8'd2) ? 2 : int'(prev_gap);
        rise_cyc = cyc;
        in_gap   = 1'b1;
        b2b      = 1'b1;
      end
      chk("rd_strobe", fifo_read_enable, pred_rd);
      chk("busy", busy, exp_busy);
      chk("update_done", dac_update_done, rise);
      chk("frame_count", frame_count, model_fc);
      if (fifo_read_enable) begin
        chk("pop_while_empty", fifo_empty, 0);
        pops++;
        rd_cyc = cyc;
        if (b2b) rdgap_q.push_back(cyc - rise_cyc);
      end
      if (sync_n) chk("sclk_idle_high", sclk, 1);
      if (!busy) chk("din_idle_zero", din, 0);
      if (in_gap) chk("din_hold_bit0", din, cap[0]);
      // Load cycle: word formed from popped data and pd_mode at that moment.
      if (prev_rd) expq.push_back({2'b00, pd_mode, fifo_read_data, 4'h0});
      if (fall) begin
        chk("sync_latency", cyc - rd_cyc, 2);
        if (b2b) begin
          chk("sync_high_b2b", cyc - rise_cyc, gap_eff + 2);
          hi_q.push_back(cyc - rise_cyc);
        end
        b2b = 1'b0; lowlen = 0; nbits = 0; cap = 16'h0;
      end
      if (!sync_n) begin
        lowlen++;
        if (prev_sclk && !sclk) begin
          cap = {cap[14:0], prev_din};
          nbits++;
        end
      end
      nxt_rd   = 1'b0;
      nxt_busy = exp_busy;
      if (!exp_busy && dac_enable && !fifo_empty) begin
        nxt_rd = 1'b1; nxt_busy = 1'b1;
      end
      if (in_gap && cyc == rise_cyc + gap_eff - 1) begin
        in_gap = 1'b0;
        if (dac_enable && !fifo_empty) nxt_rd = 1'b1;
        else begin nxt_busy = 1'b0; b2b = 1'b0; end
      end
      pred_rd  = nxt_rd;
      exp_busy = nxt_busy;
    end
    prev_sync = sync_n;
    prev_sclk = sclk;
    prev_din  = din;
    prev_rd   = fifo_read_enable;
    prev_gap  = gap_counts;
  end

  task automatic push(input logic [7:0] d);
    @(posedge clk); #1;
    fq.push_back(d);
    fifo_empty = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_sync_low(input int budget);
    int k = 0;
    while (sync_n && k < budget) begin @(posedge clk); #1; k++; end
    chk("wait_sync_low", sync_n, 0);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (busy && k < budget) begin @(posedge clk); #1; k++; end
    chk("wait_idle", busy, 0);
  endtask

  task automatic clear_logs();
    got_words.delete(); hi_q.delete(); rdgap_q.delete();
  endtask

  function automatic logic [15:0] gw(input int i);
    return (got_words.size() > i) ? got_words[i] : 16'hDEAD;
  endfunction

  function automatic int qv(input int q[$], input int i);
    return (q.size() > i) ? q[i] : -1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, d0;
    // T1: reset state, then one frame of 0xA5.
    cycles(3);
    chk("t1_rst_sync_n", sync_n, 1);
    chk("t1_rst_sclk", sclk, 1);
    chk("t1_rst_din", din, 0);
    chk("t1_rst_rd", fifo_read_enable, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_fc", frame_count, 0);
    reset = 1'b1;
    dac_enable = 1'b1;
    cycles(2);
    clear_logs();
    push(8'hA5);
    wait_sync_low(20);
    wait_idle(200);
    chk("t1_nframes", got_words.size(), 1);
    chk("t1_word", gw(0), 16'h0A50);
    chk("t1_fc", frame_count, 1);
    chk("t1_pops", pops, 1);
    chk("t1_dones", dones, 1);

    // T2: three back-to-back frames, gap 5.
    gap_counts = 8'd5;
    clear_logs();
    p0 = pops;
    push(8'h00); push(8'hFF); push(8'h3C);
    wait_sync_low(20);
    wait_idle(400);
    chk("t2_nframes", got_words.size(), 3);
    chk("t2_word0", gw(0), 16'h0000);
    chk("t2_word1", gw(1), 16'h0FF0);
    chk("t2_word2", gw(2), 16'h03C0);
    chk("t2_pops", pops - p0, 3);
    chk("t2_gap_to_pop0", qv(rdgap_q, 0), 5);
    chk("t2_gap_to_pop1", qv(rdgap_q, 1), 5);
    chk("t2_sync_high0", qv(hi_q, 0), 7);
    chk("t2_sync_high1", qv(hi_q, 1), 7);
    chk("t2_fc", frame_count, 4);

    // T3: gap 0 floors to 2; pd_mode changed mid-frame applies to next frame only.
    gap_counts = 8'd0;
    clear_logs();
    push(8'h11); push(8'h22);
    wait_sync_low(20);
    cycles(6);
    pd_mode = 2'b11;
    wait_idle(400);
    pd_mode = 2'b00;
    chk("t3_word0", gw(0), 16'h0110);
    chk("t3_word1", gw(1), 16'h3220);
    chk("t3_gap_to_pop", qv(rdgap_q, 0), 2);
    chk("t3_sync_high", qv(hi_q, 0), 4);

    // T4: drop enable at bit 7 with FIFO still non-empty.
    gap_counts = 8'd3;
    clear_logs();
    p0 = pops;
    d0 = dones;
    push(8'h44); push(8'h55);
    wait_sync_low(20);
    cycles(14);
    dac_enable = 1'b0;
    wait_idle(200);
    chk("t4_nframes", got_words.size(), 1);
    chk("t4_word", gw(0), 16'h0440);
    chk("t4_dones", dones - d0, 1);
    chk("t4_busy", busy, 0);
    chk("t4_fifo_left", fifo_empty, 0);
    cycles(10);
    chk("t4_no_more_pops", pops - p0, 1);

    // T5: reset at bit 10 aborts the frame carrying 0x55.
    clear_logs();
    dac_enable = 1'b1;
    wait_sync_low(20);
    cycles(20);
    reset = 1'b0;
    #1;
    chk("t5_sync_n", sync_n, 1);
    chk("t5_sclk", sclk, 1);
    chk("t5_din", din, 0);
    chk("t5_fc", frame_count, 0);
    chk("t5_busy", busy, 0);
    cycles(2);
    reset = 1'b1;
    p0 = pops;
    cycles(10);
    chk("t5_idle_sync", sync_n, 1);
    chk("t5_no_pop", pops - p0, 0);
    push(8'h66);
    wait_sync_low(20);
    wait_idle(200);
    chk("t5_nframes", got_words.size(), 1);
    chk("t5_word", gw(0), 16'h0660);
    chk("t5_fc_after", frame_count, 1);

    // T6: frame counter wraps 0xFFFF -> 0.
    clear_logs();
    @(posedge clk); #1;
    force dut.frame_count = 16'hFFFF;
    model_fc = 16'hFFFF;
    @(posedge clk); #1;
    release dut.frame_count;
    cycles(2);
    chk("t6_preload", frame_count, 16'hFFFF);
    push(8'h77);
    wait_sync_low(20);
    wait_idle(200);
    chk("t6_wrap", frame_count, 16'h0000);
    chk("t6_word", gw(0), 16'h0770);

    cycles(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
